// File: rtl/uart_cmd_bridge.sv
// UART command bridge: decodes byte-serial write/read frames into single 32-bit
// bus transactions and streams the response (ACK byte or read data) back out.
module uart_cmd_bridge #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd2400,
  parameter logic [7:0]  CMD_WR      = 8'h57,
  parameter logic [7:0]  CMD_RD      = 8'h52,
  parameter logic [7:0]  ACK_BYTE    = 8'h4B
) (
  input  logic        CLK,
  input  logic        nPORESET,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        bus_req,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS, RESP} state_t;

  state_t      state, state_nxt;
  logic        is_wr;
  logic [1:0]  byte_idx;
  logic [1:0]  idx_nxt;
  logic [15:0] to_cnt;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_byte;

  logic cmd_ok, load_addr, load_wdata, start_bus, bus_done, tx_take, err_inc;

  assign cmd_ok  = (rx_data == CMD_WR) || (rx_data == CMD_RD);
  assign tx_take = tx_valid & tx_ready;
  assign idx_nxt = byte_idx + 2'd1;

  always_ff @(posedge CLK or negedge nPORESET) begin
    if (!nPORESET) state <= IDLE;
    else           state <= state_nxt;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path through it can leave a variable unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    load_addr  = 1'b0;
    load_wdata = 1'b0;
    start_bus  = 1'b0;
    bus_done   = 1'b0;
    err_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (cmd_ok) state_nxt = ADDR;
          else        err_inc   = 1'b1;
        end
      end
      ADDR: begin
        // A byte arriving on the timeout cycle wins over the timeout.
        if (rx_valid) begin
          load_addr = 1'b1;
          if (byte_idx == 2'd3) begin
            if (is_wr) begin
              state_nxt = WDATA;
            end else begin
              state_nxt = BUS;
              start_bus = 1'b1;
            end
          end
        end else if (to_cnt >= TIMEOUT_CYC - 16'd1) begin
          err_inc   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WDATA: begin
        if (rx_valid) begin
          load_wdata = 1'b1;
          if (byte_idx == 2'd3) begin
            state_nxt = BUS;
            start_bus = 1'b1;
          end
        end else if (to_cnt >= TIMEOUT_CYC - 16'd1) begin
          err_inc   = 1'b1;
          state_nxt = IDLE;
        end
      end
      BUS: begin
        err_inc = rx_valid;
        if (bus_ack) begin
          bus_done  = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        err_inc = rx_valid;
        if (tx_take && (is_wr || byte_idx == 2'd3)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rsp_byte = rsp_data[31:24];
    case (idx_nxt)
      2'd1:    rsp_byte = rsp_data[23:16];
      2'd2:    rsp_byte = rsp_data[15:8];
      2'd3:    rsp_byte = rsp_data[7:0];
      default: rsp_byte = rsp_data[31:24];
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nPORESET) begin
    if (!nPORESET) begin
      is_wr     <= 1'b0;
      byte_idx  <= 2'd0;
      to_cnt    <= 16'd0;
      rsp_data  <= 32'd0;
      bus_req   <= 1'b0;
      bus_write <= 1'b0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'd0;
      err_cnt   <= 8'd0;
    end else begin
      if (rx_valid)                          to_cnt <= 16'd0;
      else if (state == ADDR || state == WDATA) to_cnt <= to_cnt + 16'd1;
      else                                   to_cnt <= 16'd0;

      if (state == IDLE && rx_valid && cmd_ok) begin
        is_wr    <= (rx_data == CMD_WR);
        byte_idx <= 2'd0;
      end else if (load_addr || load_wdata || (state == RESP && tx_take)) begin
        byte_idx <= idx_nxt;
      end

      if (load_addr)  bus_addr  <= {bus_addr[23:0], rx_data};
      if (load_wdata) bus_wdata <= {bus_wdata[23:0], rx_data};

      if (start_bus) begin
        bus_req   <= 1'b1;
        bus_write <= is_wr;
      end

      if (bus_done) begin
        bus_req  <= 1'b0;
        tx_valid <= 1'b1;
        if (is_wr) begin
          tx_data <= ACK_BYTE;
        end else begin
          rsp_data <= bus_rdata;
          tx_data  <= bus_rdata[31:24];
        end
      end else if (state == RESP && tx_take) begin
        if (is_wr || byte_idx == 2'd3) tx_valid <= 1'b0;
        else                           tx_data  <= rsp_byte;
      end

      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Scoreboard bench for uart_cmd_bridge: stimulus pushes expected bus
// transactions and tx bytes; a negedge monitor pops and compares them.
module tb_uart_cmd_bridge;

  localparam logic [15:0] T = 16'd40;

  logic        CLK, nPORESET;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        bus_req, bus_write, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  err_cnt;

  uart_cmd_bridge #(.TIMEOUT_CYC(T)) dut (
    .CLK(CLK), .nPORESET(nPORESET),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .bus_req(bus_req), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .err_cnt(err_cnt)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_exp_t;

  bus_exp_t    exp_bus[$];
  logic [7:0]  exp_tx[$];
  bus_exp_t    cur_bus;
  logic        have_cur = 1'b0;
  logic        bus_req_q = 1'b0;

  int checks = 0;
  int failures = 0;
  int exp_err = 0;
  int tx_stall = 0;
  int bus_delay = 2;
  logic ack_en = 1'b1;
  logic [31:0] rd_value = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Bus slave: acks bus_delay cycles after seeing a request.
  initial begin
    int bcnt;
    bus_ack = 1'b0;
    bus_rdata = 32'd0;
    bcnt = 0;
    forever begin
      @(posedge CLK); #1;
      if (!nPORESET || !bus_req || bus_ack || !ack_en) begin
        bus_ack = 1'b0;
        bcnt = 0;
      end else if (bcnt >= bus_delay) begin
        bus_ack = 1'b1;
        bus_rdata = rd_value;
      end else begin
        bcnt++;
      end
    end
  end

  // Serializer: holds tx_ready low tx_stall cycles per byte, then pulses it.
  initial begin
    int scnt;
    tx_ready = 1'b0;
    scnt = 0;
    forever begin
      @(posedge CLK); #1;
      if (tx_valid && !tx_ready) begin
        if (scnt >= tx_stall) begin
          tx_ready = 1'b1;
          scnt = 0;
        end else begin
          scnt++;
        end
      end else begin
        tx_ready = 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    if (!nPORESET) begin
      bus_req_q = 1'b0;
      have_cur = 1'b0;
    end else begin
      if (bus_req && !bus_req_q) begin
        if (exp_bus.size() == 0) check("unexpected_bus_req", {31'd0, bus_req}, 32'd0);
        else begin
          cur_bus = exp_bus.pop_front();
          have_cur = 1'b1;
        end
      end
      if (bus_req && have_cur) begin
        check("bus_write", {31'd0, bus_write}, {31'd0, cur_bus.wr});
        check("bus_addr", bus_addr, cur_bus.addr);
        if (cur_bus.wr) check("bus_wdata", bus_wdata, cur_bus.wdata);
      end
      if (!bus_req) have_cur = 1'b0;
      if (tx_valid && exp_tx.size() > 0) check("tx_data", {24'd0, tx_data}, {24'd0, exp_tx[0]});
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) check("unexpected_tx", {31'd0, tx_valid}, 32'd0);
        else void'(exp_tx.pop_front());
      end
      bus_req_q = bus_req;
    end
  end

  task automatic send_now(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge CLK); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK); #1;
    send_now(b);
  endtask

  task automatic send_frame(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    send_byte(wr ? 8'h57 : 8'h52);
    for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8]);
    if (wr) for (int i = 3; i >= 0; i--) send_byte(wdata[8*i +: 8]);
  endtask

  task automatic expect_write(input logic [31:0] addr, input logic [31:0] wdata);
    bus_exp_t e;
    e.wr = 1'b1; e.addr = addr; e.wdata = wdata;
    exp_bus.push_back(e);
    exp_tx.push_back(8'h4B);
  endtask

  task automatic expect_read(input logic [31:0] addr, input logic [31:0] rdata);
    bus_exp_t e;
    e.wr = 1'b0; e.addr = addr; e.wdata = 32'd0;
    exp_bus.push_back(e);
    rd_value = rdata;
    for (int i = 3; i >= 0; i--) exp_tx.push_back(rdata[8*i +: 8]);
  endtask

  task automatic wait_idle(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge CLK); #1;
      done = (exp_bus.size() == 0) && (exp_tx.size() == 0) && !bus_req && !tx_valid;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_tx(input logic level, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      if (tx_valid == level) seen = 1'b1;
      else begin @(posedge CLK); #1; end
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    nPORESET = 1'b0;
    rx_data = 8'd0;
    rx_valid = 1'b0;
    #1;
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_bus_write", {31'd0, bus_write}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    repeat (3) @(posedge CLK);
    #1 nPORESET = 1'b1;

    // Write frame
    expect_write(32'h12345678, 32'hDEADBEEF);
    send_frame(1'b1, 32'h12345678, 32'hDEADBEEF);
    wait_idle("write_done");

    // Read frame with a slow serializer and a stray byte during BUS
    tx_stall = 5;
    bus_delay = 6;
    expect_read(32'h00000040, 32'hCAFEF00D);
    send_frame(1'b0, 32'h00000040, 32'd0);
    send_now(8'h99);
    exp_err++;
    wait_idle("read_done");
    check("err_after_stray", {24'd0, err_cnt}, exp_err);
    tx_stall = 0;
    bus_delay = 2;

    // Bad command followed by a normal read
    send_byte(8'h33);
    exp_err++;
    repeat (3) @(posedge CLK); #1;
    check("bad_cmd_no_req", {31'd0, bus_req}, 32'd0);
    check("bad_cmd_err", {24'd0, err_cnt}, exp_err);
    expect_read(32'h00000100, 32'h01020304);
    send_frame(1'b0, 32'h00000100, 32'd0);
    wait_idle("read_after_bad");

    // Timeout after a partial frame, checked on both sides of the limit
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
    repeat (T - 1) @(posedge CLK); #1;
    check("timeout_not_yet", {24'd0, err_cnt}, exp_err);
    @(posedge CLK); #1;
    exp_err++;
    check("timeout_err", {24'd0, err_cnt}, exp_err);
    check("timeout_no_req", {31'd0, bus_req}, 32'd0);
    expect_write(32'hA0B1C2D3, 32'h01020304);
    send_frame(1'b1, 32'hA0B1C2D3, 32'h01020304);
    wait_idle("frame_after_timeout");

    // Byte on the timeout cycle is accepted
    send_byte(8'h52); send_byte(8'h00);
    repeat (T - 2) @(posedge CLK);
    expect_read(32'h00000040, 32'h11223344);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
    wait_idle("byte_beats_timeout");
    check("no_timeout_err", {24'd0, err_cnt}, exp_err);

    // Back-to-back: command byte in the first IDLE cycle after a response
    expect_write(32'h00001000, 32'h5555AAAA);
    send_frame(1'b1, 32'h00001000, 32'h5555AAAA);
    wait_tx(1'b1, "b2b_tx_up");
    wait_tx(1'b0, "b2b_tx_down");
    expect_read(32'h00000008, 32'h8BADF00D);
    send_now(8'h52);
    for (int i = 3; i >= 0; i--) send_byte(8'h00 | ((i == 0) ? 8'h08 : 8'h00));
    wait_idle("back_to_back");
    check("b2b_err", {24'd0, err_cnt}, exp_err);

    // Reset while a bus transaction is outstanding
    ack_en = 1'b0;
    begin
      bus_exp_t e;
      e.wr = 1'b1; e.addr = 32'hABCD0000; e.wdata = 32'h01234567;
      exp_bus.push_back(e);
    end
    send_frame(1'b1, 32'hABCD0000, 32'h01234567);
    repeat (3) @(posedge CLK); #1;
    check("pre_rst_bus_req", {31'd0, bus_req}, 32'd1);
    nPORESET = 1'b0;
    #1;
    exp_err = 0;
    check("mid_rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("mid_rst_err", {24'd0, err_cnt}, 32'd0);
    check("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    @(posedge CLK); #1;
    nPORESET = 1'b1;
    ack_en = 1'b1;
    repeat (30) @(posedge CLK); #1;
    check("no_reissue_req", {31'd0, bus_req}, 32'd0);
    check("no_reissue_tx", {31'd0, tx_valid}, 32'd0);

    // Saturation
    repeat (300) send_byte(8'h33);
    @(posedge CLK); #1;
    check("err_saturated", {24'd0, err_cnt}, 32'h000000FF);

    check("exp_bus_empty", exp_bus.size(), 32'd0);
    check("exp_tx_empty", exp_tx.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_bridge.md
UART_CMD_BRIDGE -- requirements
Module: uart_cmd_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16'd2400: inter-byte timeout in CLK cycles while a frame is partially received.
REQ-002 SHALL have parameter CMD_WR, default 8'h57: command byte for a 32-bit write.
REQ-003 SHALL have parameter CMD_RD, default 8'h52: command byte for a 32-bit read.
REQ-004 SHALL have parameter ACK_BYTE, default 8'h4B: response byte sent after a completed write.
REQ-005 SHALL have ports in this order:
- CLK  in  1  the single clock; all logic on its rising edge.
- nPORESET  in  1  reset, asynchronous, active-low.
- rx_data  in  8  received byte from the UART deserializer.
- rx_valid  in  1  one-cycle strobe qualifying rx_data.
- bus_req  out  1  bus request, held until bus_ack.
- bus_write  out  1  1 = write, 0 = read; stable while bus_req is high.
- bus_addr  out  32  transaction address.
- bus_wdata  out  32  write data.
- bus_ack  in  1  one-cycle completion strobe from the bus.
- bus_rdata  in  32  read data, valid when bus_ack is high.
- tx_data  out  8  response byte to the UART serializer.
- tx_valid  out  1  response byte valid.
- tx_ready  in  1  serializer accepts the byte when tx_valid and tx_ready are both high.
- err_cnt  out  8  saturating protocol-error counter.

Function
REQ-006 SHALL implement the states IDLE, ADDR, WDATA, BUS and RESP.
REQ-007 In IDLE:
- rx_valid with CMD_WR or CMD_RD -> latch the command type, clear the byte index, go to ADDR.
- any other byte -> stay in IDLE and increment err_cnt.
REQ-008 In ADDR, four rx_valid bytes SHALL load bus_addr MSB first: the first byte goes to [31:24], the fourth to [7:0].
REQ-009 After the fourth address byte, the next state SHALL be WDATA for a write and BUS for a read.
REQ-010 In WDATA, four bytes SHALL load bus_wdata MSB first, and the next state SHALL be BUS.
REQ-011 bus_req SHALL assert in the first cycle of BUS, with bus_write, bus_addr and bus_wdata stable, and SHALL remain high until bus_ack is sampled high.
REQ-012 On bus_ack:
- bus_req deasserts in the next cycle.
- For a read, bus_rdata is captured into a 32-bit response register.
- The next state is RESP.
REQ-013 In RESP:
- A write SHALL emit ACK_BYTE once.
- A read SHALL emit four bytes of the captured data, MSB first.
- Each byte SHALL advance only on tx_valid & tx_ready; tx_data SHALL stay stable while tx_valid is high and tx_ready is low.
- After the last byte is accepted, the state SHALL return to IDLE and tx_valid SHALL deassert in that same cycle.
REQ-014 The timeout counter SHALL reload to 0 on every rx_valid and increment each cycle while in ADDR or WDATA. Reaching TIMEOUT_CYC-1 SHALL:
- force IDLE,
- discard the partial frame,
- increment err_cnt.
REQ-015 rx_valid during BUS or RESP SHALL drop the byte and increment err_cnt, with no other effect.
REQ-016 err_cnt SHALL saturate at 8'hFF and never wrap.
REQ-017 A timeout and an rx_valid in the same cycle SHALL resolve in favour of the byte: the byte is accepted and no timeout occurs.
REQ-018 Back-to-back frames SHALL be accepted: a command byte arriving in the cycle after the return to IDLE is decoded normally.
REQ-019 At most one bus transaction SHALL be outstanding; there is no bus timeout.

Reset
REQ-020 While nPORESET is low, the following SHALL hold asynchronously:
- state = IDLE;
- bus_req = 0, bus_write = 0, bus_addr = 0, bus_wdata = 0;
- tx_valid = 0, tx_data = 0;
- err_cnt = 0;
- the timeout counter, the byte index and the response register = 0.
REQ-021 Reset asserted mid-frame or mid-bus-transaction SHALL abort the frame. After release, the block SHALL wait in IDLE for a fresh command byte and SHALL NOT reissue the aborted transaction.

Verification
REQ-022 Write: bytes 57,12,34,56,78,DE,AD,BE,EF -> one bus_req with bus_write=1, bus_addr=32'h12345678, bus_wdata=32'hDEADBEEF; after bus_ack -> tx byte 4B.
REQ-023 Read: bytes 52,00,00,00,40; bus_ack with bus_rdata=32'hCAFEF00D -> tx bytes CA,FE,F0,0D in order; tx_ready held low 5 cycles per byte -> tx_data stable throughout.
REQ-024 Bad command: byte 33 -> no bus_req, err_cnt=1; a subsequent valid read frame completes normally.
REQ-025 Timeout: bytes 52,00,00 then silence for TIMEOUT_CYC cycles -> IDLE, err_cnt=1, no bus_req; a following full frame succeeds.
REQ-026 Reset in BUS: bus_req high, nPORESET pulsed low -> bus_req=0 immediately, no tx output, no reissue after release.
REQ-027 Saturation: 300 invalid command bytes -> err_cnt=8'hFF.
